issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 162 ++++++++++++++++
 tb/tb_issue_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// ============================================================================
// issue_scoreboard : in-order multi-slot issue gate with a load-latency
//                    register scoreboard and optional perf counters
//                    (optional feature macro: ISSUE_PERF_CNT_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module issue_scoreboard #(
    parameter int ISSUE_W  = 2,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(ISSUE_W+1)-1:0]   fifo_count,
    input  logic                           stall_in,
    input  logic                           flush,
    input  logic [5*ISSUE_W-1:0]           s_rs,
    input  logic [5*ISSUE_W-1:0]           s_rt,
    input  logic [5*ISSUE_W-1:0]           s_dst,
    input  logic [ISSUE_W-1:0]             s_reg_en,
    input  logic [ISSUE_W-1:0]             s_load,
    input  logic [ISSUE_W-1:0]             s_mem,
    input  logic [ISSUE_W-1:0]             s_branch,
    input  logic [ISSUE_W-1:0]             s_priv,
    input  logic [ISSUE_W-1:0]             s_hilo,
    input  logic [ISSUE_W-1:0]             s_tlb_err,
    output logic [ISSUE_W-1:0]             issue_mask,
    output logic [$clog2(ISSUE_W+1)-1:0]   issue_cnt,
    output logic [31:0]                    busy_regs,
    output logic [CNT_W-1:0]               perf_dual,
    output logic [CNT_W-1:0]               perf_raw
);

    localparam int              SB_W    = $clog2(LOAD_LAT+1);
    localparam int              IC_W    = $clog2(ISSUE_W+1);
    localparam logic [SB_W-1:0] C_LAT   = SB_W'(LOAD_LAT);

    logic [4:0]         w_rs  [ISSUE_W];
    logic [4:0]         w_rt  [ISSUE_W];
    logic [4:0]         w_dst [ISSUE_W];
    logic [ISSUE_W-1:0] w_issue;
    logic [IC_W-1:0]    w_cnt;
    logic               w_load_set;
    logic [SB_W-1:0]    sb_q [32];
    logic [SB_W-1:0]    sb_d [32];

    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_slot
        assign w_rs[gi]  = s_rs [5*gi +: 5];
        assign w_rt[gi]  = s_rt [5*gi +: 5];
        assign w_dst[gi] = s_dst[5*gi +: 5];
    end

    for (genvar gr = 0; gr < 32; gr++) begin : g_busy
        assign busy_regs[gr] = |sb_q[gr];
    end

    // Each slot's grant folds in its predecessor's, so the mask is always a prefix.
    always_comb begin
        logic ok;
        w_issue = '0;
        ok = !rst && (fifo_count != '0) && !stall_in && !flush &&
             !busy_regs[w_rs[0]] && !busy_regs[w_rt[0]];
        w_issue[0] = ok;
        for (int i = 1; i < ISSUE_W; i++) begin
            ok = ok && (fifo_count > IC_W'(i)) &&
                 !s_mem[i] && !s_branch[i] && !s_priv[i] && !s_hilo[i] &&
                 !s_tlb_err[i] && !s_priv[0] &&
                 !busy_regs[w_rs[i]] && !busy_regs[w_rt[i]];
            for (int j = 0; j < i; j++) begin
                if (s_reg_en[j] && (w_dst[j] != 5'd0) &&
                    ((w_dst[j] == w_rs[i]) || (w_dst[j] == w_rt[i]) ||
                     (w_dst[j] == w_dst[i]))) begin
                    ok = 1'b0;
                end
            end
            w_issue[i] = ok;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_cnt = w_cnt + IC_W'(w_issue[i]);
        end
    end

    assign issue_mask = w_issue;
    assign issue_cnt  = w_cnt;
    assign w_load_set = w_issue[0] && s_load[0] && s_reg_en[0] && (w_dst[0] != 5'd0);

    // Flush beats a load set; a load set beats the countdown of the same register.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            sb_d[r] = sb_q[r];
            if (flush) begin
                sb_d[r] = '0;
            end else if (!stall_in) begin
                if (w_load_set && (w_dst[0] == 5'(r))) begin
                    sb_d[r] = C_LAT;
                end else if (sb_q[r] != '0) begin
                    sb_d[r] = sb_q[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                sb_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                sb_q[r] <= sb_d[r];
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_dual_q, perf_dual_d;
    logic [CNT_W-1:0] perf_raw_q,  perf_raw_d;
    logic             w_dual;
    logic             w_raw;

    assign w_dual = (w_cnt == IC_W'(ISSUE_W));
    assign w_raw  = (fifo_count != '0) && !stall_in && !flush &&
                    (busy_regs[w_rs[0]] || busy_regs[w_rt[0]]);

    always_comb begin
        perf_dual_d = perf_dual_q;
        perf_raw_d  = perf_raw_q;
        if (w_dual && (perf_dual_q != '1)) perf_dual_d = perf_dual_q + 1'b1;
        if (w_raw  && (perf_raw_q  != '1)) perf_raw_d  = perf_raw_q  + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dual_q <= '0;
            perf_raw_q  <= '0;
        end else begin
            perf_dual_q <= perf_dual_d;
            perf_raw_q  <= perf_raw_d;
        end
    end

    assign perf_dual = perf_dual_q;
    assign perf_raw  = perf_raw_q;
`else
    assign perf_dual = '0;
    assign perf_raw  = '0;
`endif

    // Attribute bits that have no meaning for the slot they belong to.
    logic w_unused;
    assign w_unused = ^{s_load[ISSUE_W-1:1], s_reg_en[ISSUE_W-1], s_mem[0],
                        s_branch[0], s_hilo[0], s_tlb_err[0]};

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// ============================================================================
// tb_issue_scoreboard : self-checking bench for issue_scoreboard (ISSUE_W=2,
//                       LOAD_LAT=2); expected masks flow through a queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fifo_count;
    logic        stall_in, flush;
    logic [9:0]  s_rs, s_rt, s_dst;
    logic [1:0]  s_reg_en, s_load, s_mem, s_branch, s_priv, s_hilo, s_tlb_err;
    logic [1:0]  issue_mask;
    logic [1:0]  issue_cnt;
    logic [31:0] busy_regs;
    logic [31:0] perf_dual, perf_raw;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  exp_q [$];

    issue_scoreboard #(.ISSUE_W(2), .LOAD_LAT(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .fifo_count(fifo_count), .stall_in(stall_in),
        .flush(flush), .s_rs(s_rs), .s_rt(s_rt), .s_dst(s_dst),
        .s_reg_en(s_reg_en), .s_load(s_load), .s_mem(s_mem),
        .s_branch(s_branch), .s_priv(s_priv), .s_hilo(s_hilo),
        .s_tlb_err(s_tlb_err), .issue_mask(issue_mask), .issue_cnt(issue_cnt),
        .busy_regs(busy_regs), .perf_dual(perf_dual), .perf_raw(perf_raw)
    );

    always #5 clk = ~clk;

    task automatic clr();
        fifo_count = 2'd0; stall_in = 1'b0; flush = 1'b0;
        s_rs = '0; s_rt = '0; s_dst = '0; s_reg_en = '0; s_load = '0;
        s_mem = '0; s_branch = '0; s_priv = '0; s_hilo = '0; s_tlb_err = '0;
    endtask

    task automatic slot(input int i, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic en, input logic ld);
        s_rs[5*i +: 5] = rs; s_rt[5*i +: 5] = rt; s_dst[5*i +: 5] = dst;
        s_reg_en[i] = en; s_load[i] = ld;
    endtask

    task automatic test_reset();
        logic [1:0] m;
        rst = 1'b1; clr(); fifo_count = 2'd2;
        slot(0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1); slot(1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0);
        exp_q.push_back(2'b00);
        @(negedge clk); #1;
        m = exp_q.pop_front(); checks++;
        if (issue_mask !== m) begin errors++; $display("FAIL reset_mask: got %b want %b", issue_mask, m); end
        checks++;
        if (busy_regs !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_regs); end
        checks++;
        if (perf_dual !== 32'd0 || perf_raw !== 32'd0) begin
            errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_dual, perf_raw);
        end
        @(negedge clk); rst = 1'b0; clr();
    endtask

    task automatic test_dual();
        logic [1:0] m;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); clr(); fifo_count = 2'd2;
            slot(0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0); slot(1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0);
            exp_q.push_back(2'b11); #1;
            m = exp_q.pop_front(); checks++;
            if (issue_mask !== m || issue_cnt !== 2'd2) begin
                errors++; $display("FAIL dual[%0d]: got mask %b cnt %0d want %b cnt 2", k, issue_mask, issue_cnt, m);
            end
        end
    endtask

    task automatic test_load_latency();
        logic [1:0] m;
        @(negedge clk); clr(); fifo_count = 2'd1; slot(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        exp_q.push_back(2'b01); #1;
        m = exp_q.pop_front(); checks++;
        if (issue_mask !== m) begin errors++; $display("FAIL load_issue: got %b want %b", issue_mask, m); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); clr(); fifo_count = 2'd1; slot(0, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
            exp_q.push_back((k == 3) ? 2'b01 : 2'b00); #1;
            m = exp_q.pop_front(); checks++;
            if (issue_mask !== m) begin errors++; $display("FAIL load_wait[t+%0d]: got %b want %b", k, issue_mask, m); end
            checks++;
            if (busy_regs[7] !== (k < 3)) begin
                errors++; $display("FAIL load_busy[t+%0d]: got %b want %b", k, busy_regs[7], (k < 3));
            end
        end
    endtask

    task automatic test_perf();
        checks++;
`ifdef ISSUE_PERF_CNT_EN
        if (perf_dual !== 32'd10 || perf_raw !== 32'd2) begin
            errors++; $display("FAIL perf: got dual %0d raw %0d want 10/2", perf_dual, perf_raw);
        end
`else
        if (perf_dual !== 32'd0 || perf_raw !== 32'd0) begin
            errors++; $display("FAIL perf_off: got dual %0d raw %0d want 0/0", perf_dual, perf_raw);
        end
`endif
    endtask

    task automatic test_intra_group();
        logic [1:0] m;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); clr(); fifo_count = 2'd2;
            slot(0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); slot(1, 5'd6, 5'd0, 5'd10, 1'b1, 1'b0);
            case (k)
                0: begin slot(1, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0); exp_q.push_back(2'b01); end
                1: begin slot(0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
                         slot(1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0); exp_q.push_back(2'b11); end
                2: begin slot(1, 5'd6, 5'd0, 5'd5, 1'b1, 1'b0); exp_q.push_back(2'b01); end
                3: begin s_mem[1] = 1'b1; exp_q.push_back(2'b01); end
                4: begin s_priv[0] = 1'b1; exp_q.push_back(2'b01); end
                5: begin fifo_count = 2'd1; exp_q.push_back(2'b01); end
                6: begin fifo_count = 2'd0; exp_q.push_back(2'b00); end
                7: begin stall_in = 1'b1; exp_q.push_back(2'b00); end
                default: begin s_reg_en[0] = 1'b0; slot(1, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0);
                               exp_q.push_back(2'b11); end
            endcase
            #1;
            m = exp_q.pop_front(); checks++;
            if (issue_mask !== m) begin errors++; $display("FAIL intra[%0d]: got %b want %b", k, issue_mask, m); end
        end
    endtask

    task automatic test_load_stall();
        logic [1:0] m;
        @(negedge clk); clr(); fifo_count = 2'd1; slot(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        exp_q.push_back(2'b01); #1;
        m = exp_q.pop_front(); checks++;
        if (issue_mask !== m) begin errors++; $display("FAIL stall_load: got %b want %b", issue_mask, m); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); clr(); fifo_count = 2'd1; slot(0, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
            stall_in = (k == 1);
            exp_q.push_back((k == 4) ? 2'b01 : 2'b00); #1;
            m = exp_q.pop_front(); checks++;
            if (issue_mask !== m || busy_regs[7] !== (k < 4)) begin
                errors++; $display("FAIL stall_wait[t+%0d]: got %b busy %b want %b busy %b",
                                   k, issue_mask, busy_regs[7], m, (k < 4));
            end
        end
    endtask

    task automatic test_set_wins();
        logic [1:0] m;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk); clr(); fifo_count = 2'd1;
            if (k < 2) slot(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
            else       slot(0, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
            exp_q.push_back((k < 2 || k == 4) ? 2'b01 : 2'b00); #1;
            m = exp_q.pop_front(); checks++;
            if (issue_mask !== m) begin errors++; $display("FAIL set_wins[%0d]: got %b want %b", k, issue_mask, m); end
        end
    endtask

    task automatic test_slot1_busy();
        logic [1:0] m;
        @(negedge clk); clr(); fifo_count = 2'd1; slot(0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
        #1;
        @(negedge clk); clr(); fifo_count = 2'd2;
        slot(0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0); slot(1, 5'd0, 5'd12, 5'd4, 1'b1, 1'b0);
        exp_q.push_back(2'b01); #1;
        m = exp_q.pop_front(); checks++;
        if (issue_mask !== m) begin errors++; $display("FAIL slot1_busy: got %b want %b", issue_mask, m); end
        repeat (2) @(negedge clk);
        clr();
    endtask

    task automatic test_flush();
        logic [1:0] m;
        @(negedge clk); clr(); fifo_count = 2'd1; slot(0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        #1;
        @(negedge clk); clr(); fifo_count = 2'd1; flush = 1'b1; slot(0, 5'd9, 5'd0, 5'd8, 1'b1, 1'b0);
        exp_q.push_back(2'b00); #1;
        m = exp_q.pop_front(); checks++;
        if (issue_mask !== m || busy_regs[9] !== 1'b1) begin
            errors++; $display("FAIL flush_cycle: got %b busy %b want %b busy 1", issue_mask, busy_regs[9], m);
        end
        @(negedge clk); flush = 1'b0;
        exp_q.push_back(2'b01); #1;
        m = exp_q.pop_front(); checks++;
        if (issue_mask !== m || busy_regs !== 32'h0) begin
            errors++; $display("FAIL flush_after: got %b busy %h want %b busy 0", issue_mask, busy_regs, m);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] m;
        @(negedge clk); clr(); fifo_count = 2'd1; slot(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        #1;
        @(negedge clk); clr(); fifo_count = 2'd2;
        slot(0, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0); slot(1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0);
        #1; rst = 1'b1; #1;
        checks++;
        if (busy_regs !== 32'h0 || issue_mask !== 2'b00) begin
            errors++; $display("FAIL reset_async: got busy %h mask %b want 0/00", busy_regs, issue_mask);
        end
        @(negedge clk); rst = 1'b0;
        exp_q.push_back(2'b11); #1;
        m = exp_q.pop_front(); checks++;
        if (issue_mask !== m) begin errors++; $display("FAIL reset_discard: got %b want %b", issue_mask, m); end
        @(negedge clk); clr();
    endtask

    initial begin
        test_reset();
        test_dual();
        test_load_latency();
        test_perf();
        test_intra_group();
        test_load_stall();
        test_set_wins();
        test_slot1_busy();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
